// File: rtl/cacheline_adaptor_pkg.sv
// Shared constants and state encoding for the line-to-burst adaptor.
package cacheline_adaptor_pkg;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned BEAT_W      = 64;
  localparam int unsigned BEATS       = 4;
  localparam int unsigned LINE_W      = BEATS * BEAT_W;
  localparam int unsigned OFFSET_BITS = 5;
  localparam int unsigned CNT_W       = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;
endpackage

// File: rtl/cacheline_adaptor_line_beat_buffer.sv
// One cache line of storage: whole-line load, per-beat indexed load, beat-select read mux.
module line_beat_buffer
  import cacheline_adaptor_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load_line,
  input  logic [LINE_W-1:0] i_line,
  input  logic              i_beat_we,
  input  logic [CNT_W-1:0]  i_beat_idx,
  input  logic [BEAT_W-1:0] i_beat_data,
  input  logic [CNT_W-1:0]  i_sel_idx,
  output logic [LINE_W-1:0] o_line,
  output logic [BEAT_W-1:0] o_beat
);
  logic [LINE_W-1:0] r_line;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_line <= '0;
    end else if (i_load_line) begin
      r_line <= i_line;
    end else if (i_beat_we) begin
      r_line[BEAT_W*i_beat_idx +: BEAT_W] <= i_beat_data;
    end
  end

  assign o_line = r_line;
  assign o_beat = r_line[BEAT_W*i_sel_idx +: BEAT_W];
endmodule

// File: rtl/cacheline_adaptor.sv
// Converts 256-bit line reads/writes into 4-beat 64-bit bursts. Separate read and write
// buffers keep line_rdata untouched by write traffic.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_line_address,
  input  logic [LINE_W-1:0] i_line_wdata,
  input  logic              i_line_read,
  input  logic              i_line_write,
  output logic              o_line_resp,
  output logic [LINE_W-1:0] o_line_rdata,
  output logic [ADDR_W-1:0] o_burst_address,
  output logic              o_burst_read,
  output logic              o_burst_write,
  output logic [BEAT_W-1:0] o_burst_wdata,
  input  logic [BEAT_W-1:0] i_burst_rdata,
  input  logic              i_burst_resp
);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFFSET_BITS) - ADDR_W'(1));

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_line_resp;
  logic [ADDR_W-1:0] r_burst_address;
  logic              r_burst_read;
  logic              r_burst_write;
  logic [BEAT_W-1:0] r_burst_wdata;

  logic              w_accept_wr;
  logic              w_rd_we;
  logic              w_last;
  logic [CNT_W-1:0]  w_next_idx;
  logic [BEAT_W-1:0] w_wr_beat;
  logic [BEAT_W-1:0] w_rd_beat_unused;
  logic [LINE_W-1:0] w_wr_line_unused;

  assign w_accept_wr = (r_state == IDLE) && !i_line_read && i_line_write;
  assign w_rd_we     = (r_state == READ) && i_burst_resp;
  assign w_last      = (r_cnt == CNT_W'(BEATS - 1));
  assign w_next_idx  = r_cnt + CNT_W'(1);

  line_beat_buffer u_rd_buf (
    .clk         (clk),
    .rst         (rst),
    .i_load_line (1'b0),
    .i_line      ('0),
    .i_beat_we   (w_rd_we),
    .i_beat_idx  (r_cnt),
    .i_beat_data (i_burst_rdata),
    .i_sel_idx   (r_cnt),
    .o_line      (o_line_rdata),
    .o_beat      (w_rd_beat_unused)
  );

  line_beat_buffer u_wr_buf (
    .clk         (clk),
    .rst         (rst),
    .i_load_line (w_accept_wr),
    .i_line      (i_line_wdata),
    .i_beat_we   (1'b0),
    .i_beat_idx  ('0),
    .i_beat_data ('0),
    .i_sel_idx   (w_next_idx),
    .o_line      (w_wr_line_unused),
    .o_beat      (w_wr_beat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_line_resp     <= 1'b0;
      r_burst_address <= '0;
      r_burst_read    <= 1'b0;
      r_burst_write   <= 1'b0;
      r_burst_wdata   <= '0;
    end else begin
      r_line_resp <= 1'b0;
      unique case (r_state)
        IDLE: begin
          // Read takes priority; a simultaneous write must be re-presented.
          if (i_line_read) begin
            r_burst_address <= i_line_address & ALIGN_MASK;
            r_cnt           <= '0;
            r_burst_read    <= 1'b1;
            r_state         <= READ;
          end else if (i_line_write) begin
            r_burst_address <= i_line_address & ALIGN_MASK;
            r_cnt           <= '0;
            r_burst_wdata   <= i_line_wdata[BEAT_W-1:0];
            r_burst_write   <= 1'b1;
            r_state         <= WRITE;
          end
        end
        READ: begin
          if (i_burst_resp) begin
            if (w_last) begin
              r_burst_read <= 1'b0;
              r_cnt        <= '0;
              r_line_resp  <= 1'b1;
              r_state      <= RESP;
            end else begin
              r_cnt <= w_next_idx;
            end
          end
        end
        WRITE: begin
          if (i_burst_resp) begin
            if (w_last) begin
              r_burst_write <= 1'b0;
              r_cnt         <= '0;
              r_line_resp   <= 1'b1;
              r_state       <= RESP;
            end else begin
              r_cnt         <= w_next_idx;
              r_burst_wdata <= w_wr_beat;
            end
          end
        end
        RESP: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_line_resp     = r_line_resp;
  assign o_burst_address = r_burst_address;
  assign o_burst_read    = r_burst_read;
  assign o_burst_write   = r_burst_write;
  assign o_burst_wdata   = r_burst_wdata;
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: reads, gapped writes, back-to-back, priority, reset.
module tb_cacheline_adaptor;
  import cacheline_adaptor_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] line_address;
  logic [LINE_W-1:0] line_wdata;
  logic              line_read;
  logic              line_write;
  logic              line_resp;
  logic [LINE_W-1:0] line_rdata;
  logic [ADDR_W-1:0] burst_address;
  logic              burst_read;
  logic              burst_write;
  logic [BEAT_W-1:0] burst_wdata;
  logic [BEAT_W-1:0] burst_rdata;
  logic              burst_resp;

  int n_tests = 0;
  int n_fail  = 0;

  logic [LINE_W-1:0] line1, wline, line_a, line_b, line_c, line_d, exp_fresh;
  int                k;
  logic              got;

  cacheline_adaptor dut (
    .clk             (clk),
    .rst             (rst),
    .i_line_address  (line_address),
    .i_line_wdata    (line_wdata),
    .i_line_read     (line_read),
    .i_line_write    (line_write),
    .o_line_resp     (line_resp),
    .o_line_rdata    (line_rdata),
    .o_burst_address (burst_address),
    .o_burst_read    (burst_read),
    .o_burst_write   (burst_write),
    .o_burst_wdata   (burst_wdata),
    .i_burst_rdata   (burst_rdata),
    .i_burst_resp    (burst_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                     input logic [LINE_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    line1  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    for (int i = 0; i < 32; i++) wline[8*i +: 8] = 8'(i);
    line_a = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
              64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
    line_b = {64'hB3B3_1111_2222_3333, 64'hB2B2_4444_5555_6666,
              64'hB1B1_7777_8888_9999, 64'hB0B0_AAAA_BBBB_CCCC};
    line_c = {64'hC3C3_C3C3_C3C3_C3C3, 64'hC2C2_C2C2_C2C2_C2C2,
              64'hC1C1_C1C1_C1C1_C1C1, 64'hC0C0_C0C0_C0C0_C0C0};
    line_d = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
              64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};
    exp_fresh = {64'hF00D_0000_0000_0003, 64'hF00D_0000_0000_0002,
                 64'hF00D_0000_0000_0001, 64'hF00D_0000_0000_0000};

    rst = 1'b1; line_address = '0; line_wdata = '0; line_read = 1'b0; line_write = 1'b0;
    burst_rdata = '0; burst_resp = 1'b0;
    tick; tick;
    rst = 1'b0;
    chk("reset_line_resp", line_resp, 0);
    chk("reset_line_rdata", line_rdata, 0);
    chk("reset_burst_address", burst_address, 0);
    chk("reset_burst_read", burst_read, 0);
    chk("reset_burst_write", burst_write, 0);
    chk("reset_burst_wdata", burst_wdata, 0);

    // Read, consecutive beats starting at T0+2
    line_address = 32'h0000_1234; line_read = 1'b1;
    tick;
    chk("rd_address", burst_address, 32'h0000_1220);
    chk("rd_burst_read", burst_read, 1);
    chk("rd_no_write", burst_write, 0);
    tick;
    for (int b = 0; b < 4; b++) begin
      chk("rd_no_early_resp", line_resp, 0);
      burst_resp = 1'b1; burst_rdata = line1[64*b +: 64];
      tick;
    end
    burst_resp = 1'b0;
    chk("rd_resp", line_resp, 1);
    chk("rd_burst_read_drop", burst_read, 0);
    chk("rd_line", line_rdata, line1);
    tick;
    line_read = 1'b0;
    chk("rd_resp_one_cycle", line_resp, 0);

    // Write with burst_resp on cycles 2,5,6,9 after accept
    line_address = 32'h8000_0040; line_wdata = wline; line_write = 1'b1;
    tick;
    chk("wr_address", burst_address, 32'h8000_0040);
    k = 0;
    for (int c = 1; c <= 9; c++) begin
      chk("wr_burst_write", burst_write, 1);
      chk("wr_beat", burst_wdata, wline[64*k +: 64]);
      chk("wr_line_resp_low", line_resp, 0);
      burst_resp = (c == 2 || c == 5 || c == 6 || c == 9);
      tick;
      if (burst_resp) k++;
    end
    burst_resp = 1'b0;
    chk("wr_resp", line_resp, 1);
    chk("wr_burst_write_drop", burst_write, 0);
    chk("wr_rdata_untouched", line_rdata, line1);
    tick;
    line_write = 1'b0;
    chk("wr_resp_one_cycle", line_resp, 0);

    // Back-to-back: read A, then write B presented in the cycle after RESP
    line_address = 32'h0000_0100; line_read = 1'b1;
    tick;
    for (int b = 0; b < 4; b++) begin
      burst_resp = 1'b1; burst_rdata = line_a[64*b +: 64];
      tick;
    end
    burst_resp = 1'b0;
    chk("b2b_resp_a", line_resp, 1);
    chk("b2b_rdata_a", line_rdata, line_a);
    tick;
    line_read = 1'b0; line_write = 1'b1; line_wdata = line_b; line_address = 32'h0000_0200;
    tick;
    chk("b2b_wr_accept", burst_write, 1);
    for (int b = 0; b < 4; b++) begin
      chk("b2b_no_overlap", burst_read & burst_write, 0);
      chk("b2b_beat", burst_wdata, line_b[64*b +: 64]);
      burst_resp = 1'b1; burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      tick;
    end
    burst_resp = 1'b0;
    chk("b2b_resp_b", line_resp, 1);
    chk("b2b_rdata_still_a", line_rdata, line_a);
    tick;
    line_write = 1'b0;

    // Simultaneous read and write: read wins
    line_read = 1'b1; line_write = 1'b1; line_address = 32'h0000_0040; line_wdata = line_b;
    tick;
    chk("sim_read", burst_read, 1);
    for (int b = 0; b < 4; b++) begin
      chk("sim_no_write", burst_write, 0);
      burst_resp = 1'b1; burst_rdata = line_c[64*b +: 64];
      tick;
    end
    burst_resp = 1'b0;
    chk("sim_resp", line_resp, 1);
    chk("sim_rdata", line_rdata, line_c);
    chk("sim_no_write_resp", burst_write, 0);
    tick;
    line_read = 1'b0; line_write = 1'b0;
    tick;
    chk("sim_write_dropped", burst_write, 0);

    // Reset after beat 2 of a read
    line_address = 32'h0000_0300; line_read = 1'b1;
    tick;
    for (int b = 0; b < 2; b++) begin
      burst_resp = 1'b1; burst_rdata = line_d[64*b +: 64];
      tick;
    end
    burst_resp = 1'b0; rst = 1'b1; line_read = 1'b0;
    tick;
    chk("rst_burst_read", burst_read, 0);
    chk("rst_line_resp", line_resp, 0);
    chk("rst_line_rdata", line_rdata, 0);
    chk("rst_address", burst_address, 0);
    rst = 1'b0;
    tick;
    chk("rst_idle_no_resp", line_resp, 0);
    chk("rst_idle_no_read", burst_read, 0);

    // Fresh read after reset, beats every cycle, bounded wait for line_resp
    line_address = 32'h0000_03FF; line_read = 1'b1;
    tick;
    chk("fresh_address", burst_address, 32'h0000_03E0);
    k = 0; got = 1'b0;
    while (k < 12 && !got) begin
      burst_resp = 1'b1; burst_rdata = 64'hF00D_0000_0000_0000 | 64'(k);
      tick;
      if (line_resp) got = 1'b1;
      k++;
    end
    burst_resp = 1'b0;
    chk("fresh_resp_seen", got, 1);
    chk("fresh_beat_count", k, 4);
    chk("fresh_rdata", line_rdata, exp_fresh);
    tick;
    line_read = 1'b0;

    // Spurious burst_resp in IDLE
    for (int c = 0; c < 3; c++) begin
      burst_resp = 1'b1; burst_rdata = '1;
      tick;
      chk("spur_no_resp", line_resp, 0);
      chk("spur_no_burst", burst_read | burst_write, 0);
    end
    burst_resp = 1'b0;
    chk("spur_rdata_kept", line_rdata, exp_fresh);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
